uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the command system's UART transmitter.
- Samples the serial line using the same bit timing as the transmitter: each bit lasts SAMPLES_PER_BIT clk cycles, no separate baud enable.
- Frame format: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Recovers each byte and presents it to the command decoder with a one-cycle valid strobe; framing errors are flagged.

Parameters:
- SAMPLES_PER_BIT, 16, clk cycles per bit; must be even and >= 4. Counter width is clog2(SAMPLES_PER_BIT).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rx  input  1  serial line, asynchronous to clk, idles high
- data_out  output  8  last correctly received byte; held until the next good frame
- rx_valid  output  1  one-cycle pulse; data_out is new
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- parity_err  output  1  one-cycle pulse; parity mismatch (tied 0 without RX_PARITY_EN)
- busy  output  1  high while a frame is in progress (any state except IDLE)
- state  output  3  current FSM state, for debug

Behaviour:
- Reset values: data_out=0, rx_valid=0, frame_err=0, parity_err=0, busy=0, state=IDLE, all counters 0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser; the FSM uses only the synchronised value rxs.
- State encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5.
- Sample counter: cnt counts 0..SAMPLES_PER_BIT-1, then wraps to 0. H = SAMPLES_PER_BIT/2 - 1.
- IDLE:
  - rxs==0 -> go to START, cnt=0.
- START:
  - At cnt==H (mid start bit): if rxs==1, the start was a glitch -> go to IDLE, no flags.
  - Otherwise set cnt=0, bit_cnt=0, go to DATA.
  - From here on, every sample falls mid-bit: one sample at each cnt==SAMPLES_PER_BIT-1.
- DATA:
  - At each sample point, shift rxs into shift_reg[bit_cnt] (LSB first), then increment bit_cnt.
  - After bit 7: go to PARITY if RX_PARITY_EN is defined, else go to STOP.
- STOP, at the sample point:
  - rxs==1 and no parity error -> data_out<=shift_reg, rx_valid=1 for one cycle, go to IDLE.
  - rxs==0 -> frame_err=1 for one cycle, data_out unchanged, go to BREAK.
- Returning to IDLE at mid stop bit is required, so a back-to-back start bit is caught.
- BREAK:
  - Stay until rxs==1, then go to IDLE. A held-low line produces exactly one frame_err.
- Latency: rx_valid asserts 2 (synchroniser) + H+1 + 9*SAMPLES_PER_BIT cycles after rx falls (+SAMPLES_PER_BIT with parity).
- Strobes: rx_valid, frame_err and parity_err are mutually exclusive; at most one pulse per frame.
- No backpressure: a new byte overwrites data_out.
- Reset mid-frame:
  - The partial frame is discarded and all outputs return to reset values.
  - After release, the receiver waits in IDLE for a fresh falling edge.
  - If rx is low at release, it is treated as a start bit, validated at mid-bit.
- Unused state encodings go to IDLE.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - Frame carries an even-parity bit after the data bits, sampled in PARITY at the mid-bit point; then go to STOP.
  - At the stop sample, a parity mismatch with a good stop bit gives parity_err=1 for one cycle, no rx_valid, data_out unchanged, go to IDLE.
  - A bad stop bit takes priority: frame_err only.
- Not defined:
  - PARITY state is never entered and parity_err is constant 0.

Test Plan:
- Transmitter drives 0xA5 into rx (SAMPLES_PER_BIT=16) -> one rx_valid pulse, data_out=0xA5, frame_err=0, busy falls with rx_valid.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three rx_valid pulses, in order, values match.
- rx low for 5 cycles, then high -> returns to IDLE from START, no strobes, data_out unchanged.
- Frame 0x55 with stop bit forced low, then rx held low 100 cycles -> one frame_err pulse, no rx_valid, state=BREAK until rx rises, data_out keeps the previous value.
- rst asserted mid DATA of 0x81, then a clean 0x42 -> no strobe for the aborted frame; 0x42 received correctly.
- RX_PARITY_EN: 0x07 with parity bit 1 -> rx_valid, data_out=0x07; same byte with parity bit 0 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, 1 start / 8 data (LSB first) / 1 stop, sampled mid-bit.
// Optional macro RX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_out_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          state_q;
  logic            sync1_q;
  logic            rxs_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            rx_valid_q;
  logic            frame_err_q;
  logic            busy_q;
  logic            sample_pt_s;

`ifdef RX_PARITY_EN
  logic            parity_bit_q;
  logic            parity_err_q;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rxs_q   <= sync1_q;
    end
  end

  assign sample_pt_s = (cnt_q == CNT_LAST);

  // Free-running sample counter, wraps after the last sample of a bit
  always_comb begin
    cnt_d = '0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Receive FSM with registered strobes and data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_cnt_q <= 3'd0;
            if (rxs_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (sample_pt_s) begin
            shift_q[bit_cnt_q] <= rxs_q;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
        S_PARITY: begin
`ifdef RX_PARITY_EN
          cnt_q <= cnt_d;
          if (sample_pt_s) begin
            parity_bit_q <= rxs_q;
            state_q      <= S_STOP;
          end
`else
          cnt_q   <= '0;
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`endif
        end
        S_STOP: begin
          cnt_q <= cnt_d;
          if (sample_pt_s) begin
            cnt_q <= '0;
            // A low stop bit wins over any parity result
            if (!rxs_q) begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
`ifdef RX_PARITY_EN
            else if (even_parity(shift_q) != parity_bit_q) begin
              parity_err_q <= 1'b1;
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
            end
`endif
            else begin
              data_q     <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
            end
          end
        end
        S_BREAK: begin
          cnt_q <= '0;
          if (rxs_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_o  = data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = busy_q;
  assign state_o     = state_q;
`ifdef RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes against a frame-level model.
module tb_uart_rx;

  localparam int SPB = 16;
  localparam int H   = SPB / 2 - 1;
`ifdef RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       busy_o;
  logic [2:0] state_o;

  uart_rx #(.SAMPLES_PER_BIT(SPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx),
    .data_out_o   (data_out_o),
    .rx_valid_o   (rx_valid_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed side
  logic [7:0] got_mem [0:63];
  int got_n = 0, got_ferr = 0, got_perr = 0;
  int multi_strobe = 0, busy_at_valid = 0, last_lat = 0;

  // Model side
  logic [7:0] exp_mem [0:63];
  int exp_n = 0, exp_ferr = 0, exp_perr = 0, chk_n = 0;
  logic [7:0] exp_data = 8'h00;
  int fall_cyc = 0;

  always @(negedge clk) begin
    if (rx_valid_o) begin
      got_mem[got_n] <= data_out_o;
      got_n          <= got_n + 1;
      last_lat       <= cyc - fall_cyc;
      if (busy_o) busy_at_valid <= busy_at_valid + 1;
    end
    if (frame_err_o)  got_ferr <= got_ferr + 1;
    if (parity_err_o) got_perr <= got_perr + 1;
    if ((32'(rx_valid_o) + 32'(frame_err_o) + 32'(parity_err_o)) > 32'd1)
      multi_strobe <= multi_strobe + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(SPB);
  endtask

  // Frame-level reference: what one complete frame should produce
  task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    if (!stop_bit) begin
      exp_ferr++;
    end else if (PBITS == 1 && par_bit != ^b) begin
      exp_perr++;
    end else begin
      exp_mem[exp_n] = b;
      exp_n++;
      exp_data = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
    model_frame(b, stop_bit, par_bit);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_valid_count"}, got_n, exp_n);
    for (int i = chk_n; i < exp_n; i++)
      check({tag, "_byte"}, 32'(got_mem[i]), 32'(exp_mem[i]));
    chk_n = exp_n;
    check({tag, "_frame_err_count"}, got_ferr, exp_ferr);
    check({tag, "_parity_err_count"}, got_perr, exp_perr);
    check({tag, "_data_out"}, 32'(data_out_o), 32'(exp_data));
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       par;
    logic [7:0] bb [0:2];

    rst = 1'b1;
    rx  = 1'b1;
    tick(4);
    check("rst_data_out",   32'(data_out_o),   32'h00);
    check("rst_rx_valid",   32'(rx_valid_o),   32'h0);
    check("rst_frame_err",  32'(frame_err_o),  32'h0);
    check("rst_parity_err", 32'(parity_err_o), 32'h0);
    check("rst_busy",       32'(busy_o),       32'h0);
    check("rst_state",      32'(state_o),      32'h0);
    rst = 1'b0;
    tick(2 * SPB);

    // Single frame, with latency counted from the first clk edge that sees rx low
    b = 8'hA5;
    send_frame(b, 1'b1, ^b);
    tick(SPB);
    check_stream("a5");
    check("a5_latency", last_lat, 2 + H + 1 + (9 + PBITS) * SPB + 1);
    check("a5_idle_after", 32'(state_o), 32'h0);

    // Back-to-back frames with no idle gap
    bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h3C;
    for (int i = 0; i < 3; i++) send_frame(bb[i], 1'b1, ^bb[i]);
    tick(SPB);
    check_stream("b2b");

    // Short low glitch: START entered, then abandoned at mid-bit
    rx = 1'b0;
    tick(4);
    check("glitch_in_start", 32'(state_o), 32'h1);
    tick(1);
    rx = 1'b1;
    tick(2 * SPB);
    check("glitch_back_idle", 32'(state_o), 32'h0);
    check_stream("glitch");

    // Bad stop bit followed by a held-low line
    b = 8'h55;
    send_frame(b, 1'b0, ^b);
    tick(100);
    check("break_state", 32'(state_o), 32'h5);
    check("break_busy", 32'(busy_o), 32'h1);
    check_stream("break");
    rx = 1'b1;
    tick(8);
    check("break_exit_idle", 32'(state_o), 32'h0);
    check("break_single_ferr", got_ferr, exp_ferr);

    // Reset in the middle of the data bits of 0x81
    b = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    tick(H);
    rst = 1'b1;
    rx  = 1'b1;
    tick(2);
    exp_data = 8'h00;
    check("midrst_data_out", 32'(data_out_o), 32'h00);
    check("midrst_busy",     32'(busy_o),     32'h0);
    check("midrst_state",    32'(state_o),    32'h0);
    rst = 1'b0;
    tick(2 * SPB);
    b = 8'h42;
    send_frame(b, 1'b1, ^b);
    tick(SPB);
    check_stream("after_rst");

    // Random bytes, occasional bad stop bit (and bad parity when enabled)
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      par  = ^b;
      if (PBITS == 1 && $urandom_range(0, 3) == 0) par = ~par;
      send_frame(b, stop, par);
      if (!stop) begin
        rx = 1'b1;
        tick(2 * SPB);
      end
      check_stream("random");
    end

`ifdef RX_PARITY_EN
    tick(SPB);
    b = 8'h07;
    send_frame(b, 1'b1, 1'b1);
    tick(SPB);
    check_stream("parity_good");
    send_frame(b, 1'b1, 1'b0);
    tick(SPB);
    check_stream("parity_bad");
`endif

    tick(SPB);
    check("strobes_exclusive", multi_strobe, 0);
    check("busy_falls_with_valid", busy_at_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
